// File: rtl/register_file_pkg.sv
// Shared constants and types for the RV32I integer register file.
// Imported by register_file and reg_scoreboard.
package register_file_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

  // True when a live (non-x0) destination matches a source index.
  function automatic logic addr_hit(
    input reg_addr_t dst,
    input reg_addr_t src
  );
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits marking destinations of in-flight loads.
// Flush beats set, set beats clear; entry 0 never goes busy.
module reg_scoreboard
  import register_file_pkg::*;
#(
  parameter int NUM_REGS       = register_file_pkg::NUM_REGS,
  parameter int REG_ADDR_WIDTH = register_file_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      set_en,
  input  logic [REG_ADDR_WIDTH-1:0] set_addr,
  input  logic                      clr_en,
  input  logic [REG_ADDR_WIDTH-1:0] clr_addr,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
  output logic                      busy_a,
  output logic                      busy_b
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic set_live;
  logic clr_live;

  assign set_live = set_en && (set_addr != '0);
  assign clr_live = clr_en && (clr_addr != '0);

  // Next busy vector: clear first so a same-index set overrides it.
  always_comb begin
    busy_d = busy_q;
    unique case (1'b1)
      flush: begin
        busy_d = '0;
      end
      default: begin
        if (clr_live) begin
          busy_d[clr_addr] = 1'b0;
        end
        if (set_live) begin
          busy_d[set_addr] = 1'b1;
        end
      end
    endcase
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Two lookups for the decode read ports.
  always_comb begin
    busy_a = busy_q[rd_addr_a];
    busy_b = busy_q[rd_addr_b];
  end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 2 comb reads, 1 WB write, load scoreboard.
// Optional same-cycle WB bypass under `define REGFILE_BYPASS_EN.
module register_file
  import register_file_pkg::*;
#(
  parameter int NUM_REGS       = register_file_pkg::NUM_REGS,
  parameter int REG_ADDR_WIDTH = register_file_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      RF_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] RF_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     RF_wb_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] RF_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] RF_rs2_addr_i,
  output logic [DATA_WIDTH-1:0]     RF_rs1_data_o,
  output logic [DATA_WIDTH-1:0]     RF_rs2_data_o,
  input  logic                      RF_busy_set_i,
  input  logic [REG_ADDR_WIDTH-1:0] RF_busy_addr_i,
  input  logic                      RF_flush_i,
  output logic                      RF_rs1_busy_o,
  output logic                      RF_rs2_busy_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic wr_live;
  logic rs1_zero;
  logic rs2_zero;
  logic rs1_byp;
  logic rs2_byp;
  logic sb_busy1;
  logic sb_busy2;

  assign wr_live  = RF_we_i && (RF_rd_addr_i != '0);
  assign rs1_zero = (RF_rs1_addr_i == '0);
  assign rs2_zero = (RF_rs2_addr_i == '0);

`ifdef REGFILE_BYPASS_EN
  assign rs1_byp = RF_we_i && addr_hit(RF_rd_addr_i, RF_rs1_addr_i);
  assign rs2_byp = RF_we_i && addr_hit(RF_rd_addr_i, RF_rs2_addr_i);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  // Data array: WB write, x0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[RF_rd_addr_i] <= RF_wb_data_i;
    end
  end

  // Read port 1: x0 is hardwired, bypass beats the array.
  always_comb begin
    RF_rs1_data_o = '0;
    unique case (1'b1)
      rs1_zero: RF_rs1_data_o = '0;
      rs1_byp:  RF_rs1_data_o = RF_wb_data_i;
      default:  RF_rs1_data_o = regs_q[RF_rs1_addr_i];
    endcase
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    RF_rs2_data_o = '0;
    unique case (1'b1)
      rs2_zero: RF_rs2_data_o = '0;
      rs2_byp:  RF_rs2_data_o = RF_wb_data_i;
      default:  RF_rs2_data_o = regs_q[RF_rs2_addr_i];
    endcase
  end

  reg_scoreboard #(
    .NUM_REGS       (NUM_REGS),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (RF_busy_set_i),
    .set_addr  (RF_busy_addr_i),
    .clr_en    (RF_we_i),
    .clr_addr  (RF_rd_addr_i),
    .flush     (RF_flush_i),
    .rd_addr_a (RF_rs1_addr_i),
    .rd_addr_b (RF_rs2_addr_i),
    .busy_a    (sb_busy1),
    .busy_b    (sb_busy2)
  );

  // Busy outputs: a bypassed operand is already available.
  always_comb begin
    RF_rs1_busy_o = sb_busy1 && !rs1_byp;
    RF_rs2_busy_o = sb_busy2 && !rs2_byp;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file for the RV32I pipeline.
- Consumes the writeback stage's write-data / rd / write-enable in WB.
- Supplies two combinational read ports to decode.
- Contains a per-register busy scoreboard. The scoreboard marks destinations of in-flight loads so decode can detect load-use hazards.
- Sits between writeback_stage (writer) and decode_stage (reader).

Parameters:
- NUM_REGS, 32, number of architectural registers (x0..x31).
- REG_ADDR_WIDTH, 5, register index width; must equal clog2(NUM_REGS).
- DATA_WIDTH, 32, register width; taken from the shared package.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RF_we_i  input  1  write enable from WB.
- RF_rd_addr_i  input  REG_ADDR_WIDTH  destination register from WB.
- RF_wb_data_i  input  DATA_WIDTH  writeback data (writeback_stage output).
- RF_rs1_addr_i  input  REG_ADDR_WIDTH  read port 1 address.
- RF_rs2_addr_i  input  REG_ADDR_WIDTH  read port 2 address.
- RF_rs1_data_o  output  DATA_WIDTH  read port 1 data.
- RF_rs2_data_o  output  DATA_WIDTH  read port 2 data.
- RF_busy_set_i  input  1  a load with destination RF_busy_addr_i is issued this cycle.
- RF_busy_addr_i  input  REG_ADDR_WIDTH  load destination to mark busy.
- RF_flush_i  input  1  pipeline flush; clears all busy bits.
- RF_rs1_busy_o  output  1  rs1 has a pending load.
- RF_rs2_busy_o  output  1  rs2 has a pending load.

Behaviour:
- Reset (async, rst_n=0):
  - All registers 0; all busy bits 0.
  - Read outputs reflect 0 immediately; busy outputs 0.
  - Reset mid-operation discards any pending write.
- Write:
  - On rising edge, if RF_we_i=1 and RF_rd_addr_i!=0, regs[rd] <= RF_wb_data_i.
  - Writes to x0 are ignored.
- Read:
  - Combinational, zero latency.
  - Address 0 always returns 0.
  - Otherwise returns regs[addr], subject to the optional bypass below.
- Busy scoreboard:
  - Set: on rising edge, if RF_busy_set_i=1 and RF_busy_addr_i!=0, busy[addr] <= 1.
  - Clear: on rising edge, if RF_we_i=1 and RF_rd_addr_i!=0, busy[rd] <= 0.
  - Set and clear of the same address in the same cycle: set wins, since the newly issued load is younger.
  - Set and clear of different addresses in the same cycle: both take effect.
  - RF_flush_i=1: all busy bits <= 0 on the edge.
  - Flush overrides a simultaneous set, since the issuing load is squashed.
  - Flush does not block a simultaneous register write.
  - busy[0] is always 0.
  - RF_rsN_busy_o = busy[rsN_addr], subject to the optional bypass below.
- Write-without-busy (ALU result to a non-busy register) is legal; the clear is a no-op.
- No other state; no FSM beyond the per-register busy bits.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- With the macro defined:
  - If RF_we_i=1, RF_rd_addr_i!=0 and RF_rd_addr_i==rsN_addr, then RF_rsN_data_o = RF_wb_data_i in the same cycle (write-before-read).
  - RF_rsN_busy_o is forced 0 for that register in that cycle.
- Without the macro:
  - Reads return only the stored value; new data is visible the cycle after the write edge.
  - Busy outputs reflect only registered busy bits.
  - Decode must then stall one extra cycle.

Decomposition:
- Shared package additions:
  - NUM_REGS and REG_ADDR_WIDTH constants.
  - typedef reg_addr_t (logic [REG_ADDR_WIDTH-1:0]).
  - DATA_WIDTH is reused.
- One sub-module: reg_scoreboard. It holds the busy vector with set/clear/flush priority and provides two busy lookups.
- The data array, read muxing and bypass stay in register_file.

Test Plan:
- Reset, then read x1..x31 on both ports -> all data 0, all busy 0. Assert rst_n=0 mid-write of 0xDEADBEEF to x5 -> x5 reads 0 after release.
- Write x0=0x12345678, then read rs1=0 -> 0. Write x7=0xA5A5A5A5, next cycle rs1=7, rs2=7 -> both 0xA5A5A5A5.
- Same-cycle write x9=0xCAFEF00D with rs1=9:
  - With REGFILE_BYPASS_EN -> 0xCAFEF00D that cycle.
  - Without -> old value (0) that cycle, 0xCAFEF00D the next.
- busy_set x12, then rs2=12 -> busy=1 for 3 cycles. WB write x12=0x00000042 -> busy 0 after the edge (same cycle with bypass), data 0x42.
- Same-cycle busy_set x3 and WB write x3=0x11 -> x3 data 0x11, busy stays 1. Same cycle set x4 / clear x5 (x5 pre-busy) -> x4 busy=1, x5 busy=0.
- busy x10, x11 set; then RF_flush_i with simultaneous busy_set x13 and write x14=0x77 -> busy x10, x11, x13 all 0; x14 reads 0x77.
